consumer_fsm: RTL and testbench

Downstream sink for the two global-stall pipelines: it accepts each pipeline's output word stream, buffers each lane in its own FIFO, checks per-lane sequence integrity (lane 1 even, lane 2 odd, step +2), and merges both lanes onto one valid/ready output stream. It closes the loop back to the producer by generating `stall_1`/`stall_2` from FIFO occupancy, and it re-synchronises its checkers on `flush_1`/`flush_2`.

---
 rtl/consumer_pkg.sv | 15 +
 rtl/lane_fifo.sv | 49 ++++
 rtl/consumer_fsm.sv | 156 +++++++++++++++
 tb/tb_consumer_fsm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/consumer_pkg.sv
// Shared types and constants for the two-lane consumer: lane checker states,
// lane parities and the sequence step.
package consumer_pkg;

    typedef enum logic {
        LANE_SYNC  = 1'b0,
        LANE_TRACK = 1'b1
    } lane_state_e;

    localparam logic        LANE1_PARITY = 1'b0;
    localparam logic        LANE2_PARITY = 1'b1;
    localparam int unsigned SEQ_STEP     = 2;
    localparam int unsigned NUM_LANES    = 2;

endpackage : consumer_pkg

// File: rtl/lane_fifo.sv
// Synchronous single-clock FIFO with occupancy count; pointers carry one extra
// wrap bit so full/empty come from an MSB compare.
module lane_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign count = r_wptr - r_rptr;
    assign rdata = r_mem[r_rptr[AW-1:0]];

    // A pop in the same cycle frees the head slot, so a push on full is legal then.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule : lane_fifo

// File: rtl/consumer_fsm.sv
// Two-lane pipeline sink: per-lane FIFO and sequence checker, round-robin merge
// onto one valid/ready stream, occupancy-driven stall back to the producer.
module consumer_fsm
    import consumer_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SKID       = 2,
    parameter int unsigned ERR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_1,
    input  logic [DATA_W-1:0] data_1,
    input  logic              valid_2,
    input  logic [DATA_W-1:0] data_2,
    input  logic              flush_1,
    input  logic              flush_2,
    output logic              stall_1,
    output logic              stall_2,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_lane,
    input  logic              m_ready,
    output logic [ERR_W-1:0]  err_count,
    output logic              err_flag,
    output logic              ovf_flag
);

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned STALL_TH = FIFO_DEPTH - SKID;
    localparam logic [NUM_LANES-1:0] LANE_PARITY = {LANE2_PARITY, LANE1_PARITY};

    logic [NUM_LANES-1:0] w_valid;
    logic [NUM_LANES-1:0] w_flush;
    logic [DATA_W-1:0]    w_data   [NUM_LANES];
    logic [DATA_W-1:0]    w_rdata  [NUM_LANES];
    logic [CNT_W-1:0]     w_count  [NUM_LANES];
    logic [NUM_LANES-1:0] w_full;
    logic [NUM_LANES-1:0] w_empty;
    logic [NUM_LANES-1:0] w_push;
    logic [NUM_LANES-1:0] w_pop;
    logic [NUM_LANES-1:0] w_drop;
    logic [NUM_LANES-1:0] w_err;
    logic [NUM_LANES-1:0] w_stall_nxt;
    logic                 w_load;
    logic                 w_grant_valid;
    logic                 w_grant_lane;
    logic [ERR_W:0]       w_err_sum;

    lane_state_e          r_st     [NUM_LANES];
    logic [DATA_W-1:0]    r_exp    [NUM_LANES];
    logic [NUM_LANES-1:0] r_stall;
    logic                 r_m_valid;
    logic [DATA_W-1:0]    r_m_data;
    logic                 r_m_lane;
    logic                 r_last;
    logic [ERR_W-1:0]     r_err_count;
    logic                 r_err_flag;
    logic                 r_ovf_flag;

    assign w_valid   = {valid_2, valid_1};
    assign w_flush   = {flush_2, flush_1};
    assign w_data[0] = data_1;
    assign w_data[1] = data_2;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (w_push[g]),
            .wdata (w_data[g]),
            .pop   (w_pop[g]),
            .rdata (w_rdata[g]),
            .full  (w_full[g]),
            .empty (w_empty[g]),
            .count (w_count[g])
        );
    end

    // Output register reloads when empty or being consumed; ties alternate lanes.
    assign w_load        = !r_m_valid || m_ready;
    assign w_grant_valid = w_load && (w_empty != 2'b11);
    assign w_grant_lane  = (w_empty == 2'b00) ? !r_last : w_empty[0];

    always_comb begin
        w_pop   = '0;
        w_push  = '0;
        w_drop  = '0;
        w_err   = '0;
        w_stall_nxt = '0;
        if (w_grant_valid) w_pop[w_grant_lane] = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_push[l] = w_valid[l] && (!w_full[l] || w_pop[l]);
            w_drop[l] = w_valid[l] && !w_push[l];
            // Flushing lanes skip the check; dropped words are still checked.
            if (w_valid[l] && !w_flush[l]) begin
                if (r_st[l] == LANE_SYNC) w_err[l] = (w_data[l][0] != LANE_PARITY[l]);
                else                      w_err[l] = (w_data[l] != r_exp[l]);
            end
            w_stall_nxt[l] = (32'(w_count[l]) + 32'(w_push[l]) - 32'(w_pop[l])) >= STALL_TH;
        end
        w_err_sum = {1'b0, r_err_count} + (ERR_W+1)'(w_err[0]) + (ERR_W+1)'(w_err[1]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_st[l]  <= LANE_SYNC;
                r_exp[l] <= '0;
            end
            r_stall     <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_lane    <= 1'b0;
            r_last      <= 1'b1;
            r_err_count <= '0;
            r_err_flag  <= 1'b0;
            r_ovf_flag  <= 1'b0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (w_flush[l]) begin
                    r_st[l] <= LANE_SYNC;
                end else if (w_valid[l]) begin
                    r_st[l]  <= LANE_TRACK;
                    r_exp[l] <= w_data[l] + DATA_W'(SEQ_STEP);
                end
            end
            r_stall <= w_stall_nxt;
            if (w_load) begin
                r_m_valid <= w_grant_valid;
                if (w_grant_valid) begin
                    r_m_data <= w_rdata[w_grant_lane];
                    r_m_lane <= w_grant_lane;
                    r_last   <= w_grant_lane;
                end
            end
            r_err_count <= w_err_sum[ERR_W] ? '1 : w_err_sum[ERR_W-1:0];
            r_err_flag  <= r_err_flag | (|w_err);
            r_ovf_flag  <= r_ovf_flag | (|w_drop);
        end
    end

    assign stall_1   = r_stall[0];
    assign stall_2   = r_stall[1];
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_lane    = r_m_lane;
    assign err_count = r_err_count;
    assign err_flag  = r_err_flag;
    assign ovf_flag  = r_ovf_flag;

endmodule : consumer_fsm

// File: tb/tb_consumer_fsm.sv
// Directed bench for consumer_fsm: expected merged words go into a queue when
// issued; a negedge monitor pops and compares on every accepted output word.
module tb_consumer_fsm;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned SKID       = 2;
    localparam int unsigned ERR_W      = 16;

    typedef struct packed {
        logic              lane;
        logic [DATA_W-1:0] data;
    } item_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              valid_1 = 1'b0, valid_2 = 1'b0;
    logic [DATA_W-1:0] data_1 = '0, data_2 = '0;
    logic              flush_1 = 1'b0, flush_2 = 1'b0;
    logic              stall_1, stall_2;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_lane;
    logic              m_ready = 1'b0;
    logic [ERR_W-1:0]  err_count;
    logic              err_flag;
    logic              ovf_flag;

    item_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    consumer_fsm #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SKID       (SKID),
        .ERR_W      (ERR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_1   (valid_1),
        .data_1    (data_1),
        .valid_2   (valid_2),
        .data_2    (data_2),
        .flush_1   (flush_1),
        .flush_2   (flush_2),
        .stall_1   (stall_1),
        .stall_2   (stall_2),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_lane    (m_lane),
        .m_ready   (m_ready),
        .err_count (err_count),
        .err_flag  (err_flag),
        .ovf_flag  (ovf_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: accepted words against the queue, held words for stability.
    logic  hold_prev = 1'b0;
    item_t prev_item = '0;
    always @(negedge clk) begin
        item_t e;
        if (hold_prev) begin
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_word", 64'({m_lane, m_data}), 64'(prev_item));
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got lane %0d data %0d, expected no word", m_lane, m_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_word", 64'({m_lane, m_data}), 64'(e));
            end
        end
        hold_prev = m_valid && !m_ready && reset;
        prev_item = '{lane: m_lane, data: m_data};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic [DATA_W-1:0] d1,
                         input logic v2, input logic [DATA_W-1:0] d2,
                         input logic f1, input logic f2);
        valid_1 = v1; data_1 = d1;
        valid_2 = v2; data_2 = d2;
        flush_1 = f1; flush_2 = f2;
        step();
        valid_1 = 1'b0; valid_2 = 1'b0;
        flush_1 = 1'b0; flush_2 = 1'b0;
    endtask

    task automatic expect_word(input logic lane, input int unsigned data);
        exp_q.push_back('{lane: lane, data: DATA_W'(data)});
    endtask

    task automatic drain();
        int n = 0;
        m_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) step();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_m_data"}, 64'(m_data), 64'd0);
        chk({tag, "_m_lane"}, 64'(m_lane), 64'd0);
        chk({tag, "_stall_1"}, 64'(stall_1), 64'd0);
        chk({tag, "_stall_2"}, 64'(stall_2), 64'd0);
        chk({tag, "_err_count"}, 64'(err_count), 64'd0);
        chk({tag, "_err_flag"}, 64'(err_flag), 64'd0);
        chk({tag, "_ovf_flag"}, 64'(ovf_flag), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;

        repeat (2) step();
        chk_idle_outputs("reset");
        reset = 1'b1;
        step();

        // Interleaved lanes with full-rate drain: lane 1 granted first after reset.
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_word(1'b0, 2 * i);
            expect_word(1'b1, 2 * i + 1);
            drive(1'b1, DATA_W'(2 * i), 1'b1, DATA_W'(2 * i + 1), 1'b0, 1'b0);
        end
        drain();
        chk("t1_err_count", 64'(err_count), 64'd0);
        chk("t1_err_flag", 64'(err_flag), 64'd0);

        // Lane 1 skips 4: one error, then tracking resumes from the bad word.
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        foreach (w_seq2[i]) begin
            expect_word(1'b0, w_seq2[i]);
            drive(1'b1, DATA_W'(w_seq2[i]), 1'b0, '0, 1'b0, 1'b0);
            if (i == 2) begin
                chk("t2_err_after_6", 64'(err_count), 64'd1);
                chk("t2_flag_after_6", 64'(err_flag), 64'd1);
            end
        end
        chk("t2_err_after_10", 64'(err_count), 64'd1);
        drain();

        // Output blocked: first word parks in the output register, then the FIFO fills.
        m_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            w = 12 + 2 * (k - 1);
            expect_word(1'b0, w);
            drive(1'b1, DATA_W'(w), 1'b0, '0, 1'b0, 1'b0);
            chk($sformatf("t3_stall_1_w%0d", k), 64'(stall_1), 64'(k >= 7));
            chk($sformatf("t3_stall_2_w%0d", k), 64'(stall_2), 64'd0);
        end
        chk("t3_ovf_flag", 64'(ovf_flag), 64'd0);
        chk("t3_err_count", 64'(err_count), 64'd1);
        drain();
        chk("t3_stall_1_released", 64'(stall_1), 64'd0);

        // Lane 2 overflow with the output register occupied by a lane 1 word.
        m_ready = 1'b0;
        expect_word(1'b0, 28);
        drive(1'b1, DATA_W'(28), 1'b0, '0, 1'b0, 1'b0);
        step();
        chk("t4_parked_valid", 64'(m_valid), 64'd1);
        chk("t4_parked_data", 64'(m_data), 64'd28);
        for (int k = 1; k <= 9; k++) begin
            w = 9 + 2 * (k - 1);
            if (k <= 8) expect_word(1'b1, w);
            drive(1'b0, '0, 1'b1, DATA_W'(w), 1'b0, 1'b0);
            chk($sformatf("t4_stall_2_w%0d", k), 64'(stall_2), 64'(k >= 6));
            chk($sformatf("t4_ovf_w%0d", k), 64'(ovf_flag), 64'(k == 9));
        end
        chk("t4_err_count", 64'(err_count), 64'd1);
        drain();
        chk("t4_stall_2_released", 64'(stall_2), 64'd0);

        // Flush resynchronises: 64 clean, 65 wrong parity in SYNC.
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        expect_word(1'b0, 64);
        drive(1'b1, DATA_W'(64), 1'b0, '0, 1'b0, 1'b0);
        chk("t5_err_after_64", 64'(err_count), 64'd1);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        expect_word(1'b0, 65);
        drive(1'b1, DATA_W'(65), 1'b0, '0, 1'b0, 1'b0);
        chk("t5_err_after_65", 64'(err_count), 64'd2);

        // Both lanes wrong parity in one cycle; last grant was lane 1, so lane 2 first.
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        expect_word(1'b1, 2);
        expect_word(1'b0, 1);
        drive(1'b1, DATA_W'(1), 1'b1, DATA_W'(2), 1'b0, 1'b0);
        chk("t5_err_dual", 64'(err_count), 64'd4);
        drain();
        chk("t5_err_flag", 64'(err_flag), 64'd1);
        chk("t5_ovf_flag", 64'(ovf_flag), 64'd1);

        // Reset with the output register loaded and words buffered in both FIFOs.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            drive(1'b1, DATA_W'(100 + 2 * i), 1'b1, DATA_W'(201 + 2 * i), 1'b0, 1'b0);
        chk("t6_pre_valid", 64'(m_valid), 64'd1);
        reset = 1'b0;
        step();
        chk_idle_outputs("t6_reset");
        reset = 1'b1;
        m_ready = 1'b1;
        expect_word(1'b0, 0);
        expect_word(1'b1, 1);
        expect_word(1'b0, 2);
        expect_word(1'b1, 3);
        expect_word(1'b0, 4);
        drive(1'b1, DATA_W'(0), 1'b1, DATA_W'(1), 1'b0, 1'b0);
        drive(1'b1, DATA_W'(2), 1'b1, DATA_W'(3), 1'b0, 1'b0);
        drive(1'b1, DATA_W'(4), 1'b0, '0, 1'b0, 1'b0);
        drain();
        chk("t6_err_count", 64'(err_count), 64'd0);
        chk("t6_err_flag", 64'(err_flag), 64'd0);
        chk("t6_ovf_flag", 64'(ovf_flag), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    int unsigned w_seq2 [5] = '{0, 2, 6, 8, 10};

endmodule : tb_consumer_fsm
